// File: rtl/if_stage_pkg.sv
// Purpose: Shared core package for the fetch stage. Holds the reset PC, the NOP encoding, opcodes, FSM states and queue entry type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0

    // instr[6:2] major opcodes seen by the control unit
    typedef enum logic [4:0] {
        OPC_LOAD   = 5'b00000,
        OPC_OP_IMM = 5'b00100,
        OPC_AUIPC  = 5'b00101,
        OPC_STORE  = 5'b01000,
        OPC_OP     = 5'b01100,
        OPC_LUI    = 5'b01101,
        OPC_BRANCH = 5'b11000,
        OPC_JALR   = 5'b11001,
        OPC_JAL    = 5'b11011,
        OPC_SYSTEM = 5'b11100
    } opcode_e;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_RUN,
        ST_FLUSH
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_stage_fetch_fifo.sv
// Purpose: Small circular queue for fetched {pc, instr} entries. It has push, pop, flush and an occupancy count.
// Latency: a push becomes visible at head_dat on the cycle after it is written. head_dat is combinational from storage.
// Backpressure: a push while full is dropped unless a pop happens in the same cycle. A pop while empty is ignored.
// Ports: clk, rst (async active-high), push/push_dat, pop, flush, head_dat, count, empty.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + PW'(1);  // DEPTH is a power of two, so the pointer wraps on its own
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Purpose: Instruction fetch stage. It issues sequential word reads, queues the returned words with their PCs, and handles redirects.
// Latency: a request in cycle N shows instrValid in cycle N+1, because the response bypasses the empty queue.
// Backpressure: queued entries plus outstanding responses never exceed QDEPTH. Fetch stalls while decode holds instrReady low.
// Ports: clk, rst | imemReq/imemAddr/imemRdata | redirectValid/redirectPc |
//        instrValid/instrReady/instr/pc/pcPlus4 | op/funct3/funct7_6 (decoded from the head).
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic [31:0] imemRdata,
    input  logic        redirectValid,
    input  logic [31:0] redirectPc,
    output logic        instrValid,
    input  logic        instrReady,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4,
    output logic [4:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7_6
);

    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         resp_pend_q, resp_pend_d;  // a response is on imemRdata this cycle
    logic [31:0]  resp_pc_q, resp_pc_d;
    fetch_entry_t last_q, last_d;            // head value shown while the queue is empty

    fetch_entry_t fifo_in, fifo_head, head;
    logic [CW-1:0] fifo_count;
    logic         fifo_empty, fifo_push, fifo_pop, fifo_flush;
    logic         bypass_vld, head_vld, xfer;
    logic [CW:0]  occ_after_pop;

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat (fifo_in),
        .pop      (fifo_pop),
        .flush    (fifo_flush),
        .head_dat (fifo_head),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

    always_comb begin
        // A redirect squashes the response arriving in the same cycle. It is neither shown nor queued.
        bypass_vld = resp_pend_q && !redirectValid;
        head_vld   = !fifo_empty || bypass_vld;
        if (!fifo_empty) begin
            head = fifo_head;
        end else begin
            head.pc    = resp_pc_q;
            head.instr = imemRdata;
        end
        xfer        = head_vld && instrReady;
        fifo_pop    = xfer && !fifo_empty;
        // A response goes into the queue unless decode takes it straight from the bypass
        fifo_push     = bypass_vld && !(fifo_empty && instrReady);
        fifo_in.pc    = resp_pc_q;
        fifo_in.instr = imemRdata;
        fifo_flush  = redirectValid && (state_q != ST_RESET);

        occ_after_pop = {1'b0, fifo_count} + (CW+1)'(resp_pend_q) - (CW+1)'(xfer);
        imemReq = (state_q == ST_RUN) && !redirectValid && (occ_after_pop < (CW+1)'(QDEPTH));

        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        resp_pend_d = imemReq;
        resp_pc_d   = fetch_pc_q;
        last_d      = head_vld ? head : last_q;
        case (state_q)
            ST_RESET: state_d = ST_RUN;
            ST_RUN, ST_FLUSH: begin
                if (redirectValid) begin
                    // The newest redirect target wins, even while already flushing
                    state_d    = ST_FLUSH;
                    fetch_pc_d = word_align(redirectPc);
                end else begin
                    state_d = ST_RUN;
                    if (imemReq) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RESET;
            fetch_pc_q   <= RESET_PC;
            resp_pend_q  <= 1'b0;
            resp_pc_q    <= RESET_PC;
            last_q.pc    <= RESET_PC;
            last_q.instr <= NOP_INSTR;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            resp_pend_q <= resp_pend_d;
            resp_pc_q   <= resp_pc_d;
            last_q      <= last_d;
        end
    end

    assign imemAddr   = fetch_pc_q;
    assign instrValid = head_vld;
    assign instr      = head_vld ? head.instr : last_q.instr;
    assign pc         = head_vld ? head.pc : last_q.pc;
    assign pcPlus4    = pc + 32'd4;
    assign op         = instr[6:2];
    assign funct3     = instr[14:12];
    assign funct7_6   = instr[30];

endmodule
